// File: rtl/rescale_relu_sched_pkg.sv
// rescale_relu_sched_pkg: shared state encoding, id-width helper and default constants
package rescale_relu_sched_pkg;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int DEF_M0    = 59;
    localparam int DEF_SHIFT = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rescale_relu_sched_rr_arbiter.sv
// rescale_relu_sched_rr_arbiter: round-robin grant starting at the pointer, pointer moves past
// the winner only when a grant is actually issued
module rescale_relu_sched_rr_arbiter
    import rescale_relu_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;

    // scan backwards so the last hit is the first requester at or after ptr
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt = (en && gnt_any) ? N_REQ'(1) << gnt_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (en && gnt_any)
            ptr <= gnt_idx + 1'b1;
    end

endmodule

// File: rtl/rescale_relu_sched.sv
// rescale_relu_sched: shares one multiply/round-shift/ReLU/saturate path among N_REQ producers
// with flush/drain; RESCALE_SAT_CNT_EN adds a saturated-output counter sat_count
module rescale_relu_sched
    import rescale_relu_sched_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DATA_W     = 32,
    parameter  int M0_W       = 8,
    parameter  int SHIFT      = DEF_SHIFT,
    parameter  int OUT_W      = 8,
    parameter  int M0_DEFAULT = DEF_M0,
    localparam int ID_W       = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    m0_wr_en,
    input  logic [ID_W-1:0]         m0_wr_idx,
    input  logic [M0_W-1:0]         m0_wr_data,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
`ifdef RESCALE_SAT_CNT_EN
    output logic                    busy,
    output logic [15:0]             sat_count
`else
    output logic                    busy
`endif
);

    localparam int P = DATA_W + M0_W;
    localparam logic signed [P:0] RND  = (P + 1)'(1) << (SHIFT - 1);
    localparam logic signed [P:0] MAXV = (P + 1)'((1 << OUT_W) - 1);

    state_t                   state, state_n;
    logic signed [M0_W-1:0]   m0 [N_REQ];
    logic                     s1_v;
    logic signed [P-1:0]      s1_prod;
    logic [ID_W-1:0]          s1_id;
    logic [ID_W-1:0]          gnt_idx;
    logic                     gnt_any;
    logic                     s2_load;
    logic                     s1_en;
    logic                     grant_en;
    logic                     take;
    logic signed [DATA_W-1:0] d_sel;
    logic signed [P:0]        r;

    assign s2_load  = !out_valid || out_ready;
    assign s1_en    = !s1_v || s2_load;
    assign grant_en = s1_en && state == S_RUN && !flush;
    assign take     = grant_en && gnt_any;
    assign d_sel    = req_data[gnt_idx*DATA_W +: DATA_W];
    assign r        = ($signed({s1_prod[P-1], s1_prod}) + RND) >>> SHIFT;
    assign busy     = s1_v || out_valid;

    rescale_relu_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (grant_en),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < N_REQ; i++) m0[i] <= M0_W'(M0_DEFAULT);
        else if (m0_wr_en)
            m0[m0_wr_idx] <= m0_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_prod <= '0;
            s1_id   <= '0;
        end else if (s1_en) begin
            s1_v <= take;
            if (take) begin
                s1_prod <= P'(d_sel) * P'(m0[gnt_idx]);
                s1_id   <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_data <= (r < 0) ? '0 : (r > MAXV) ? '1 : r[OUT_W-1:0];
                out_id   <= s1_id;
            end
        end
    end

    always_comb begin
        state_n = (state == S_RUN)   ? (flush ? S_DRAIN : S_RUN) :
                  (state == S_DRAIN) ? ((!s1_v && !out_valid) ? S_DONE : S_DRAIN) :
                                       (flush ? S_DONE : S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            flush_done <= state == S_DRAIN && state_n == S_DONE;
        end
    end

`ifdef RESCALE_SAT_CNT_EN
    logic out_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_sat <= 1'b0;
        else if (s2_load && s1_v)
            out_sat <= r > MAXV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_done)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_rescale_relu_sched.sv
// tb_rescale_relu_sched: directed vectors with hand-computed results for rescale_relu_sched
module tb_rescale_relu_sched;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    m0_wr_en;
    logic [1:0]              m0_wr_idx;
    logic [7:0]              m0_wr_data;
    logic                    flush;
    logic                    flush_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic [1:0]              out_id;
    logic                    busy;
`ifdef RESCALE_SAT_CNT_EN
    logic [15:0]             sat_count;
`endif

    int errors = 0;
    int checks = 0;
    int rr_exp [4] = '{23, 46, 69, 92};

    rescale_relu_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .m0_wr_en   (m0_wr_en),
        .m0_wr_idx  (m0_wr_idx),
        .m0_wr_data (m0_wr_data),
        .flush      (flush),
        .flush_done (flush_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
`ifdef RESCALE_SAT_CNT_EN
        .busy       (busy),
        .sat_count  (sat_count)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        req_valid = '0; req_data = '0; m0_wr_en = 0; m0_wr_idx = '0; m0_wr_data = '0;
        flush = 0; out_ready = 1;
        #1 rst = 1;
        cyc; cyc; #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 0);
        cyc; rst = 0;

        // round-robin, all requesters valid, results 23/46/69/92 per id
        for (int i = 0; i < N_REQ; i++) set_data(i, 100 * (i + 1));
        req_valid = 4'hF;
        for (int s = 0; s < 9; s++) begin
            if (s == 6) req_valid = '0;
            #2;
            check("rr_ready", req_ready, (s < 6) ? (1 << (s % 4)) : 0);
            check("rr_valid", out_valid, (s >= 2 && s < 8));
            if (s >= 2 && s < 8) begin
                check("rr_id", out_id, (s - 2) % 4);
                check("rr_data", out_data, rr_exp[(s - 2) % 4]);
            end
            cyc;
        end

        // single accept and negative clamp
        set_data(0, 1000); req_valid = 4'b0001; #2;
        check("t1_ready", req_ready, 4'b0001);
        cyc; req_valid = '0; #2;
        check("t1_lat_valid", out_valid, 0);
        check("t1_busy", busy, 1);
        cyc; #2;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 230);
        check("t1_id", out_id, 0);
        cyc; set_data(0, -500); req_valid = 4'b0001; #2;
        check("neg_ready_wrap", req_ready, 4'b0001);
        cyc; req_valid = '0; cyc; #2;
        check("neg_valid", out_valid, 1);
        check("neg_data", out_data, 0);

        // saturation high
        cyc; set_data(1, 10000); req_valid = 4'b0010; #2;
        check("sat_ready", req_ready, 4'b0010);
        cyc; req_valid = '0; cyc; #2;
        check("sat_data", out_data, 255);
        check("sat_id", out_id, 1);
        cyc; #2;
        check("sat_drained", out_valid, 0);
`ifdef RESCALE_SAT_CNT_EN
        check("sat_count_1", sat_count, 1);
`endif

        // M0 write in the same cycle as an accept uses the old value
        cyc; set_data(2, 1000); req_valid = 4'b0100;
        m0_wr_en = 1; m0_wr_idx = 2; m0_wr_data = 8'd10; #2;
        check("m0_ready_a", req_ready, 4'b0100);
        cyc; m0_wr_en = 0; #2;
        check("m0_ready_b", req_ready, 4'b0100);
        cyc; req_valid = '0; #2;
        check("m0_old_data", out_data, 230);
        check("m0_old_id", out_id, 2);
        cyc; #2;
        check("m0_new_data", out_data, 39);
        cyc;

        // backpressure: two accepts then stall, output held
        set_data(0, 100); set_data(1, 200); req_valid = 4'b0011; out_ready = 0;
        for (int s = 0; s < 5; s++) begin
            #2;
            check("bp_ready", req_ready, (s == 0) ? 1 : (s == 1) ? 2 : 0);
            if (s >= 2) begin
                check("bp_valid", out_valid, 1);
                check("bp_data_hold", out_data, 23);
                check("bp_id_hold", out_id, 0);
            end
            cyc;
        end
        out_ready = 1; #2;
        check("bp_resume_ready", req_ready, 4'b0001);
        cyc; #2;
        check("bp_out1_id", out_id, 1);
        check("bp_out1_data", out_data, 46);
        check("bp_ready_1", req_ready, 4'b0010);
        cyc; req_valid = '0; #2;
        check("bp_out2_id", out_id, 0);
        check("bp_out2_data", out_data, 23);
        cyc; #2;
        check("bp_out3_id", out_id, 1);
        check("bp_out3_valid", out_valid, 1);
        cyc; #2;
        check("bp_empty", out_valid, 0);

        // flush with two items in flight
        cyc; req_valid = 4'b0011; #2;
        check("fl_ready_0", req_ready, 4'b0001);
        cyc; #2;
        check("fl_ready_1", req_ready, 4'b0010);
        cyc; flush = 1; #2;
        check("fl_block", req_ready, 0);
        check("fl_out0_id", out_id, 0);
        check("fl_busy", busy, 1);
        cyc; #2;
        check("fl_block_2", req_ready, 0);
        check("fl_out1_id", out_id, 1);
        check("fl_out1_valid", out_valid, 1);
        check("fl_done_early", flush_done, 0);
        cyc; #2;
        check("fl_idle_busy", busy, 0);
        check("fl_done_wait", flush_done, 0);
        cyc; #2;
        check("fl_done_pulse", flush_done, 1);
        check("fl_block_3", req_ready, 0);
        cyc; #2;
        check("fl_done_once", flush_done, 0);
        check("fl_block_4", req_ready, 0);
`ifdef RESCALE_SAT_CNT_EN
        check("sat_count_clr", sat_count, 0);
`endif
        flush = 0;
        cyc; #2;
        check("fl_resume", req_ready, 4'b0001);
        check("fl_done_low", flush_done, 0);
        cyc; req_valid = '0; cyc; #2;
        check("fl_resume_data", out_data, 23);
        cyc;

        // reset mid-stream restores pointer and M0
        m0_wr_en = 1; m0_wr_idx = 0; m0_wr_data = 8'd5;
        cyc; m0_wr_en = 0; set_data(0, 1000); req_valid = 4'b0001;
        cyc; req_valid = '0; cyc; #2;
        check("m0_written", out_data, 20);
        cyc; set_data(1, 100); req_valid = 4'b0011; #2;
        check("rs_ready_0", req_ready, 4'b0010);
        cyc; #2;
        check("rs_ready_1", req_ready, 4'b0001);
        cyc; #2;
        check("rs_pre_valid", out_valid, 1);
        check("rs_pre_id", out_id, 1);
        req_valid = 4'hF; rst = 1; #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_out_data", out_data, 0);
        cyc; rst = 0; #2;
        check("rs_ptr", req_ready, 4'b0001);
        cyc; req_valid = '0; cyc; #2;
        check("rs_m0_default", out_data, 230);
        check("rs_id", out_id, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
